// File: rtl/ones_to_mask_if.sv
// Request/result handshake bundle for the ones_to_mask count-to-mask generator.
interface ones_to_mask_if #(
    parameter int WIDTH = 4
);
    localparam int COUNTER_SIZE = $clog2(WIDTH);

    logic                    s_valid;
    logic                    s_ready;
    logic [COUNTER_SIZE:0]   s_count;
    logic [COUNTER_SIZE-1:0] s_offset;
    logic                    m_valid;
    logic                    m_ready;
    logic [WIDTH-1:0]        m_mask;
    logic [COUNTER_SIZE:0]   m_ones;
    logic                    m_sat;

    // Request producer and result consumer.
    modport master (
        output s_valid, s_count, s_offset, m_ready,
        input  s_ready, m_valid, m_mask, m_ones, m_sat
    );

    // The mask generator.
    modport slave (
        input  s_valid, s_count, s_offset, m_ready,
        output s_ready, m_valid, m_mask, m_ones, m_sat
    );
endinterface

// File: rtl/ones_to_mask.sv
// ones_to_mask: turns a count into a contiguous, rotated run of ones.
// Stage 1 clamps the count and registers its thermometer code; stage 2
// rotates that code by the offset and drives the registered result.
module ones_to_mask #(
    parameter int WIDTH = 4
) (
    input  logic          clk,
    input  logic          rst,
    ones_to_mask_if.slave bus
);
    localparam int COUNTER_SIZE = $clog2(WIDTH);
    localparam int COUNT_W      = COUNTER_SIZE + 1;
    localparam logic [COUNT_W-1:0]      WIDTH_CNT = COUNT_W'(WIDTH);
    // WIDTH folded into offset width; subtracting it wraps correctly for
    // the offsets in [WIDTH, 2^COUNTER_SIZE) that need reducing.
    localparam logic [COUNTER_SIZE-1:0] WIDTH_OFF = COUNTER_SIZE'(WIDTH);

    // (2^n)-1 for n in [0, WIDTH].
    function automatic logic [WIDTH-1:0] thermometer(input logic [COUNT_W-1:0] n);
        logic [WIDTH-1:0] t;
        for (int i = 0; i < WIDTH; i++) begin
            t[i] = (COUNT_W'(i) < n) ? 1'b1 : 1'b0;
        end
        return t;
    endfunction

    // Rotate left by sh (sh already < WIDTH); bits leaving the top re-enter at bit 0.
    function automatic logic [WIDTH-1:0] rotl(input logic [WIDTH-1:0]        v,
                                              input logic [COUNTER_SIZE-1:0] sh);
        logic [WIDTH-1:0] r;
        int               k;
        r = {WIDTH{1'b0}};
        for (int i = 0; i < WIDTH; i++) begin
            for (int j = 0; j < WIDTH; j++) begin
                k = (i - j + WIDTH) % WIDTH;
                if (k == int'(sh)) begin
                    r[i] = v[j];
                end else begin
                    r[i] = r[i];
                end
            end
        end
        return r;
    endfunction

    logic                    s1_valid_r;
    logic [WIDTH-1:0]        s1_therm_r;
    logic [COUNT_W-1:0]      s1_ones_r;
    logic                    s1_sat_r;
    logic [COUNTER_SIZE-1:0] s1_offset_r;

    logic                    s2_valid_r;
    logic [WIDTH-1:0]        s2_mask_r;
    logic [COUNT_W-1:0]      s2_ones_r;
    logic                    s2_sat_r;

    logic                    s2_open_s;
    logic                    s1_move_s;
    logic                    s_ready_s;
    logic                    s_accept_s;
    logic                    sat_s;
    logic [COUNT_W-1:0]      n_s;
    logic [WIDTH-1:0]        therm_s;
    logic [COUNTER_SIZE-1:0] offset_s;
    logic [WIDTH-1:0]        rot_s;

    // Pipeline flow control: s_ready depends only on stage state and m_ready.
    always_comb begin
        s2_open_s  = ~s2_valid_r | bus.m_ready;
        s1_move_s  = s1_valid_r & s2_open_s;
        s_ready_s  = ~s1_valid_r | s2_open_s;
        s_accept_s = bus.s_valid & s_ready_s;
    end

    // Clamp the requested count, build its thermometer code and reduce the offset.
    always_comb begin
        sat_s = (bus.s_count > WIDTH_CNT) ? 1'b1 : 1'b0;
        if (sat_s) begin
            n_s = WIDTH_CNT;
        end else begin
            n_s = bus.s_count;
        end
        therm_s = thermometer(n_s);
        if ({1'b0, bus.s_offset} >= WIDTH_CNT) begin
            offset_s = bus.s_offset - WIDTH_OFF;
        end else begin
            offset_s = bus.s_offset;
        end
    end

    // Place the stage-1 run at its offset.
    always_comb begin
        rot_s = rotl(s1_therm_r, s1_offset_r);
    end

    // Stage 1 register: loads on accept, empties when it moves on, otherwise holds.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_r  <= 1'b0;
            s1_therm_r  <= {WIDTH{1'b0}};
            s1_ones_r   <= {COUNT_W{1'b0}};
            s1_sat_r    <= 1'b0;
            s1_offset_r <= {COUNTER_SIZE{1'b0}};
        end else if (s_accept_s) begin
            s1_valid_r  <= 1'b1;
            s1_therm_r  <= therm_s;
            s1_ones_r   <= n_s;
            s1_sat_r    <= sat_s;
            s1_offset_r <= offset_s;
        end else if (s1_move_s) begin
            s1_valid_r  <= 1'b0;
        end else begin
            s1_valid_r  <= s1_valid_r;
        end
    end

    // Stage 2 register: takes stage 1 whenever the output slot is free or being popped.
    always_ff @(posedge clk) begin
        if (rst) begin
            s2_valid_r <= 1'b0;
            s2_mask_r  <= {WIDTH{1'b0}};
            s2_ones_r  <= {COUNT_W{1'b0}};
            s2_sat_r   <= 1'b0;
        end else if (s2_open_s) begin
            s2_valid_r <= s1_valid_r;
            if (s1_valid_r) begin
                s2_mask_r <= rot_s;
                s2_ones_r <= s1_ones_r;
                s2_sat_r  <= s1_sat_r;
            end else begin
                s2_mask_r <= s2_mask_r;
            end
        end else begin
            s2_valid_r <= s2_valid_r;
        end
    end

    assign bus.s_ready = s_ready_s;
    assign bus.m_valid = s2_valid_r;
    assign bus.m_mask  = s2_mask_r;
    assign bus.m_ones  = s2_ones_r;
    assign bus.m_sat   = s2_sat_r;
endmodule

// File: tb/tb_ones_to_mask.sv
// Testbench for ones_to_mask (WIDTH=4): directed steps plus a random run,
// with a queue scoreboard filled on request handshakes and drained on results.
module tb_ones_to_mask;
    localparam int W = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;

    ones_to_mask_if #(.WIDTH(W)) bus ();

    ones_to_mask #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0] mask;
        logic [2:0] ones;
        logic       sat;
    } res_t;

    res_t sb_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    // Reference: set bits off, off+1, ... (mod W), min(cnt, W) of them.
    function automatic res_t model(input int cnt, input int off);
        res_t r;
        int   n;
        int   m;
        n = (cnt > W) ? W : cnt;
        m = 0;
        for (int k = 0; k < n; k++) begin
            m = m | (1 << ((off + k) % W));
        end
        r.mask = 4'(m);
        r.ones = 3'(n);
        r.sat  = (cnt > W);
        return r;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Drive one request and wait (bounded) for it to be accepted.
    task automatic send(input int cnt, input int off, input bit rnd_ready);
        bit acc;
        acc = 1'b0;
        bus.s_valid  = 1'b1;
        bus.s_count  = 3'(cnt);
        bus.s_offset = 2'(off);
        for (int i = 0; i < 64 && !acc; i++) begin
            @(negedge clk);
            acc = bus.s_ready;
            @(posedge clk);
            #1;
            if (rnd_ready) bus.m_ready = 1'($urandom_range(0, 1));
        end
        bus.s_valid = 1'b0;
        n_checks++;
        assert (acc) else begin
            n_fail++;
            $error("FAIL send_timeout: request %0d/%0d observed not accepted expected accepted", cnt, off);
        end
    endtask

    // Scoreboard: pop/compare on result handshakes, push on request handshakes.
    always @(negedge clk) begin
        res_t e;
        if (rst) begin
            sb_q.delete();
        end else begin
            if (bus.m_valid && bus.m_ready) begin
                n_checks++;
                assert (sb_q.size() != 0) else begin
                    n_fail++;
                    $error("FAIL unexpected_out: observed mask 0x%0h expected no output", bus.m_mask);
                end
                if (sb_q.size() != 0) begin
                    e = sb_q.pop_front();
                    check("sb_mask", bus.m_mask, e.mask);
                    check("sb_ones", bus.m_ones, e.ones);
                    check("sb_sat",  bus.m_sat,  e.sat);
                    check("sb_popcount", $countones(bus.m_mask), e.ones);
                end
            end
            if (bus.s_valid && bus.s_ready) begin
                sb_q.push_back(model(int'(bus.s_count), int'(bus.s_offset)));
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: observed simulation still running expected finished");
        $fatal(1);
    end

    initial begin
        bus.s_valid  = 1'b0;
        bus.s_count  = 3'd0;
        bus.s_offset = 2'd0;
        bus.m_ready  = 1'b0;
        rst          = 1'b1;

        // Reset state.
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_m_valid", bus.m_valid, 1'b0);
        check("rst_m_mask",  bus.m_mask,  4'b0000);
        check("rst_m_ones",  bus.m_ones,  3'd0);
        check("rst_m_sat",   bus.m_sat,   1'b0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("rst_s_ready", bus.s_ready, 1'b1);

        // Rotation with wrap and two-cycle latency.
        @(posedge clk);
        #1;
        bus.m_ready = 1'b1;
        send(2, 3, 1'b0);
        @(negedge clk);
        check("lat_early_valid", bus.m_valid, 1'b0);
        @(negedge clk);
        check("lat_valid", bus.m_valid, 1'b1);
        check("wrap_mask", bus.m_mask,  4'b1001);
        check("wrap_ones", bus.m_ones,  3'd2);
        check("wrap_sat",  bus.m_sat,   1'b0);

        // Clamp then empty, back to back.
        @(posedge clk);
        #1;
        send(5, 1, 1'b0);
        send(0, 2, 1'b0);
        @(negedge clk);
        check("clamp_mask", bus.m_mask, 4'b1111);
        check("clamp_ones", bus.m_ones, 3'd4);
        check("clamp_sat",  bus.m_sat,  1'b1);
        @(negedge clk);
        check("empty_valid", bus.m_valid, 1'b1);
        check("empty_mask",  bus.m_mask,  4'b0000);
        check("empty_ones",  bus.m_ones,  3'd0);
        repeat (3) @(posedge clk);
        #1;

        // Backpressure: fill both stages, stall, then release.
        bus.m_ready  = 1'b0;
        bus.s_valid  = 1'b1;
        bus.s_count  = 3'd1;
        bus.s_offset = 2'd0;
        @(negedge clk);
        check("bp_ready1", bus.s_ready, 1'b1);
        @(posedge clk);
        #1;
        bus.s_count  = 3'd2;
        bus.s_offset = 2'd1;
        @(negedge clk);
        check("bp_ready2", bus.s_ready, 1'b1);
        @(posedge clk);
        #1;
        bus.s_count  = 3'd3;
        bus.s_offset = 2'd2;
        @(negedge clk);
        check("bp_full_ready", bus.s_ready, 1'b0);
        @(posedge clk);
        #1;
        @(negedge clk);
        check("bp_hold_ready", bus.s_ready, 1'b0);
        check("bp_hold_valid", bus.m_valid, 1'b1);
        check("bp_hold_mask",  bus.m_mask,  4'b0001);
        @(posedge clk);
        #1;
        bus.m_ready = 1'b1;
        @(negedge clk);
        check("bp_rel_ready", bus.s_ready, 1'b1);
        check("bp_out1_mask", bus.m_mask,  4'b0001);
        @(posedge clk);
        #1;
        bus.s_valid = 1'b0;
        @(negedge clk);
        check("bp_out2_valid", bus.m_valid, 1'b1);
        check("bp_out2_mask",  bus.m_mask,  4'b0110);
        @(negedge clk);
        check("bp_out3_valid", bus.m_valid, 1'b1);
        check("bp_out3_mask",  bus.m_mask,  4'b1101);
        @(negedge clk);
        check("bp_drained", bus.m_valid, 1'b0);

        // Reset mid-flight, with a request presented during reset.
        @(posedge clk);
        #1;
        send(3, 0, 1'b0);
        rst          = 1'b1;
        bus.s_valid  = 1'b1;
        bus.s_count  = 3'd4;
        bus.s_offset = 2'd0;
        @(posedge clk);
        #1;
        rst         = 1'b0;
        bus.s_valid = 1'b0;
        @(negedge clk);
        check("midrst_s_ready", bus.s_ready, 1'b1);
        for (int i = 0; i < 6; i++) begin
            check("midrst_valid", bus.m_valid, 1'b0);
            check("midrst_no_0111", bus.m_mask == 4'b0111, 1'b0);
            @(negedge clk);
        end

        // Random requests with random backpressure.
        @(posedge clk);
        #1;
        for (int i = 0; i < 10000; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                @(posedge clk);
                #1;
                bus.m_ready = 1'($urandom_range(0, 1));
            end
            send(int'($urandom_range(0, 7)), int'($urandom_range(0, 3)), 1'b1);
        end
        bus.m_ready = 1'b1;
        repeat (6) @(posedge clk);
        @(negedge clk);
        check("drain_empty", sb_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
